// File: rtl/ext_bus_sequencer.sv
// External memory bus sequencer: round-robin arbitration between CPU (port 0) and
// loader (port 1), then a registered setup / strobe / hold cycle on the board bus.
module ext_bus_sequencer #(
   parameter int WAIT_STATES = 2,
   parameter int TURNAROUND  = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ0,
   input  logic        WE0,
   input  logic [1:0]  BE0,
   input  logic [15:0] ADDR0,
   input  logic [15:0] WDATA0,
   output logic        ACK0,
   input  logic        REQ1,
   input  logic        WE1,
   input  logic [1:0]  BE1,
   input  logic [15:0] ADDR1,
   input  logic [15:0] WDATA1,
   output logic        ACK1,
   output logic [15:0] RDATA,
   output logic [1:0]  GNT,
   output logic [15:0] ADDR,
   output logic [15:0] DOUT,
   input  logic [15:0] DIN,
   output logic        RDN,
   output logic        WR0N,
   output logic        WR1N
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t      state, state_nxt;
   logic [3:0]  wait_cnt;
   logic [2:0]  hold_cnt;
   logic        last_owner;
   logic        we;
   logic [1:0]  be;
   logic        arb;
   logic        take;
   logic        pick1;

   // The last HOLD cycle arbitrates exactly like IDLE, so a waiting request is
   // granted on the edge that leaves HOLD (5 edges per access at the defaults).
   always_comb begin
      state_nxt = state;
      arb       = 1'b0;
      take      = 1'b0;
      pick1     = 1'b0;
      case (state)
         IDLE:    arb = 1'b1;
         SETUP:   state_nxt = STROBE;
         STROBE:  if (wait_cnt == 4'd0) state_nxt = HOLD;
         HOLD:    if (hold_cnt == 3'd0) arb = 1'b1;
         default: state_nxt = IDLE;
      endcase
      if (arb) begin
         take      = REQ0 | REQ1;
         pick1     = REQ1 & (~REQ0 | ~last_owner);
         state_nxt = take ? SETUP : IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         GNT        <= 2'b00;
         ACK0       <= 1'b0;
         ACK1       <= 1'b0;
         RDATA      <= 16'h0000;
         ADDR       <= 16'h0000;
         DOUT       <= 16'h0000;
         RDN        <= 1'b1;
         WR0N       <= 1'b1;
         WR1N       <= 1'b1;
         last_owner <= 1'b1;
         we         <= 1'b0;
         be         <= 2'b00;
         wait_cnt   <= 4'd0;
         hold_cnt   <= 3'd0;
      end else begin
         ACK0 <= 1'b0;
         ACK1 <= 1'b0;
         if (arb) begin
            if (take) begin
               GNT        <= pick1 ? 2'b10 : 2'b01;
               last_owner <= pick1;
               ADDR       <= pick1 ? ADDR1  : ADDR0;
               DOUT       <= pick1 ? WDATA1 : WDATA0;
               we         <= pick1 ? WE1    : WE0;
               be         <= pick1 ? BE1    : BE0;
            end else begin
               GNT <= 2'b00;
            end
         end
         case (state)
            SETUP: begin
               RDN      <= we;
               WR0N     <= ~(we & be[0]);
               WR1N     <= ~(we & be[1]);
               wait_cnt <= 4'(WAIT_STATES);
            end
            STROBE: begin
               if (wait_cnt == 4'd0) begin
                  if (!we) RDATA <= DIN;
                  RDN      <= 1'b1;
                  WR0N     <= 1'b1;
                  WR1N     <= 1'b1;
                  ACK0     <= GNT[0];
                  ACK1     <= GNT[1];
                  hold_cnt <= 3'(TURNAROUND - 1);
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            HOLD: begin
               if (hold_cnt != 3'd0) hold_cnt <= hold_cnt - 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ext_bus_sequencer.sv
// Directed bench for ext_bus_sequencer at WAIT_STATES=2, TURNAROUND=1.
module tb_ext_bus_sequencer;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        REQ0 = 1'b0, WE0 = 1'b0, REQ1 = 1'b0, WE1 = 1'b0;
   logic [1:0]  BE0 = 2'b00, BE1 = 2'b00;
   logic [15:0] ADDR0 = 16'h0, WDATA0 = 16'h0, ADDR1 = 16'h0, WDATA1 = 16'h0;
   logic [15:0] DIN = 16'h0;
   logic        ACK0, ACK1, RDN, WR0N, WR1N;
   logic [15:0] RDATA, ADDR, DOUT;
   logic [1:0]  GNT;

   int n_chk = 0;
   int n_fail = 0;

   ext_bus_sequencer #(.WAIT_STATES(2), .TURNAROUND(1)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ0(REQ0), .WE0(WE0), .BE0(BE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .ACK0(ACK0),
      .REQ1(REQ1), .WE1(WE1), .BE1(BE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .ACK1(ACK1),
      .RDATA(RDATA), .GNT(GNT), .ADDR(ADDR), .DOUT(DOUT), .DIN(DIN),
      .RDN(RDN), .WR0N(WR0N), .WR1N(WR1N)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One access on a single port; REQ drops inside the ACK cycle.
   task automatic access(input string tag, input int port, input logic wr, input logic [1:0] be,
                         input logic [15:0] addr, input logic [15:0] wdata, input logic [15:0] din,
                         input int nrd, input int nw0, input int nw1);
      int rd = 0, w0 = 0, w1 = 0, ackn = 0, ack_at = 0, other = 0, ovl = 0;
      if (port == 0) begin
         WE0 = wr; BE0 = be; ADDR0 = addr; WDATA0 = wdata; REQ0 = 1'b1;
      end else begin
         WE1 = wr; BE1 = be; ADDR1 = addr; WDATA1 = wdata; REQ1 = 1'b1;
      end
      DIN = din;
      tick();
      chk({tag, "_gnt"}, 32'(GNT), (port == 0) ? 32'h1 : 32'h2);
      chk({tag, "_addr"}, 32'(ADDR), 32'(addr));
      chk({tag, "_setup_strb"}, {29'd0, RDN, WR0N, WR1N}, 32'h7);
      if (wr) chk({tag, "_dout"}, 32'(DOUT), 32'(wdata));
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (!RDN)  rd++;
         if (!WR0N) w0++;
         if (!WR1N) w1++;
         if (!RDN && (!WR0N || !WR1N)) ovl++;
         if ((port == 0) ? ACK1 : ACK0) other++;
         if ((port == 0) ? ACK0 : ACK1) begin
            ackn++;
            ack_at = c;
            REQ0 = 1'b0;
            REQ1 = 1'b0;
            if (!wr) chk({tag, "_rdata"}, 32'(RDATA), 32'(din));
         end
      end
      REQ0 = 1'b0;
      REQ1 = 1'b0;
      chk({tag, "_rdn_low"}, 32'(rd), 32'(nrd));
      chk({tag, "_wr0n_low"}, 32'(w0), 32'(nw0));
      chk({tag, "_wr1n_low"}, 32'(w1), 32'(nw1));
      chk({tag, "_ack_cnt"}, 32'(ackn), 32'd1);
      chk({tag, "_ack_at"}, 32'(ack_at), 32'd4);
      chk({tag, "_other_ack"}, 32'(other), 32'd0);
      chk({tag, "_overlap"}, 32'(ovl), 32'd0);
      chk({tag, "_gnt_idle"}, 32'(GNT), 32'h0);
   endtask

   initial begin
      int gcyc [4];
      int gport [4];
      int ng, a0, a1, a0_at, a1_at, dbl, both, ovl;
      logic [1:0] pg;
      logic pa0, pa1;

      RESET = 1'b1;
      tick();
      tick();
      chk("rst_strb", {29'd0, RDN, WR0N, WR1N}, 32'h7);
      chk("rst_gnt", 32'(GNT), 32'h0);
      chk("rst_ack", {30'd0, ACK0, ACK1}, 32'h0);
      chk("rst_addr", 32'(ADDR), 32'h0);
      chk("rst_dout", 32'(DOUT), 32'h0);
      chk("rst_rdata", 32'(RDATA), 32'h0);
      RESET = 1'b0;
      tick();
      chk("idle_gnt", 32'(GNT), 32'h0);

      access("cpu_rd", 0, 1'b0, 2'b00, 16'h1234, 16'h0000, 16'hBEEF, 3, 0, 0);
      access("ld_bwr", 1, 1'b1, 2'b10, 16'h8000, 16'hA55A, 16'h0000, 0, 0, 3);
      access("be00_wr", 0, 1'b1, 2'b00, 16'h0042, 16'h7777, 16'h0000, 0, 0, 0);
      access("word_wr", 0, 1'b1, 2'b11, 16'h0100, 16'h1357, 16'h0000, 0, 3, 3);

      // Contention: last owner was port 0, so port 1 wins first.
      ADDR0 = 16'h1111; WE0 = 1'b0; BE0 = 2'b00;
      ADDR1 = 16'h2222; WE1 = 1'b0; BE1 = 2'b00;
      DIN = 16'h5A5A;
      REQ0 = 1'b1;
      REQ1 = 1'b1;
      ng = 0; a0 = 0; a1 = 0; a0_at = 0; a1_at = 0; dbl = 0; both = 0; ovl = 0;
      pg = 2'b00; pa0 = 1'b0; pa1 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (GNT != pg && GNT != 2'b00 && ng < 4) begin
            gcyc[ng]  = c;
            gport[ng] = GNT[1] ? 1 : 0;
            chk($sformatf("cont_addr%0d", ng), 32'(ADDR), GNT[1] ? 32'h2222 : 32'h1111);
            ng++;
         end
         if (ACK0) begin a0++; a0_at += c; end
         if (ACK1) begin a1++; a1_at += c; end
         if ((ACK0 && pa0) || (ACK1 && pa1)) dbl++;
         if (ACK0 && ACK1) both++;
         if (GNT == 2'b11) ovl++;
         pg = GNT; pa0 = ACK0; pa1 = ACK1;
      end
      REQ0 = 1'b0;
      REQ1 = 1'b0;
      chk("cont_ngrants", 32'(ng), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("cont_port%0d", i), 32'(gport[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("cont_cyc%0d", i), 32'(gcyc[i]), 32'(1 + 5 * i));
      end
      chk("cont_ack0_cnt", 32'(a0), 32'd2);
      chk("cont_ack1_cnt", 32'(a1), 32'd2);
      chk("cont_ack0_cycles", 32'(a0_at), 32'd30);
      chk("cont_ack1_cycles", 32'(a1_at), 32'd20);
      chk("cont_ack_long", 32'(dbl), 32'd0);
      chk("cont_ack_both", 32'(both), 32'd0);
      chk("cont_gnt_both", 32'(ovl), 32'd0);
      tick();
      chk("cont_end_gnt", 32'(GNT), 32'h0);

      // Reset during the second strobe cycle of a read.
      WE0 = 1'b0; ADDR0 = 16'h3030; DIN = 16'h9999; REQ0 = 1'b1;
      tick();
      tick();
      tick();
      chk("mid_rdn_low", 32'(RDN), 32'h0);
      RESET = 1'b1;
      REQ0 = 1'b0;
      tick();
      chk("mid_strb", {29'd0, RDN, WR0N, WR1N}, 32'h7);
      chk("mid_gnt", 32'(GNT), 32'h0);
      chk("mid_addr", 32'(ADDR), 32'h0);
      chk("mid_rdata", 32'(RDATA), 32'h0);
      RESET = 1'b0;
      a0 = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (ACK0 || ACK1) a0++;
      end
      chk("mid_no_ack", 32'(a0), 32'd0);
      access("post_rst_rd", 0, 1'b0, 2'b00, 16'h4444, 16'h0000, 16'hCAFE, 3, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
